wr_pntr_full: RTL

//  Write-domain pointer and full-flag generator of the dual-clock FIFO.

---
 rtl/wr_pntr_full_pkg.sv | 24 ++
 rtl/wr_pntr_full_if.sv | 29 ++
 rtl/wr_pntr_full_gray2bin.sv | 12 +
 rtl/wr_pntr_full.sv | 83 ++++++++
 4 files changed

// File: rtl/wr_pntr_full_pkg.sv
// Shared definitions for the dual-clock FIFO pointer logic: default sizing
// and Gray/binary helpers used by both clock domains.
package wr_pntr_full_pkg;

  localparam int AWIDTH_DEF      = 4;
  localparam int ALMOST_FULL_DEF = 12;
  localparam int PW_DEF          = AWIDTH_DEF + 1;

  typedef logic [PW_DEF-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = PW_DEF - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_pntr_full_if.sv
// Write-side FIFO pointer bus: the request/read-pointer inputs and every
// flag, address and level the write-domain pointer block produces.
interface wr_pntr_full_if
  import wr_pntr_full_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF
);
  logic              wr_req_i;
  logic [AWIDTH:0]   rd_pntr_gray_i;
  logic              wr_en_o;
  logic [AWIDTH-1:0] wr_addr_o;
  logic [AWIDTH:0]   wr_pntr_gray_o;
  logic              wr_full_o;
  logic              wr_almost_full_o;
  logic [AWIDTH:0]   wr_usedw_o;
  logic              wr_ovf_o;

  modport master (
    output wr_req_i, rd_pntr_gray_i,
    input  wr_en_o, wr_addr_o, wr_pntr_gray_o, wr_full_o,
           wr_almost_full_o, wr_usedw_o, wr_ovf_o
  );

  modport slave (
    input  wr_req_i, rd_pntr_gray_i,
    output wr_en_o, wr_addr_o, wr_pntr_gray_o, wr_full_o,
           wr_almost_full_o, wr_usedw_o, wr_ovf_o
  );
endinterface

// File: rtl/wr_pntr_full_gray2bin.sv
// Parametric Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above it. Pure combinational, shared with the read side.
module wr_pntr_full_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[W-1:i];
  end
endmodule

// File: rtl/wr_pntr_full.sv
// Write-domain pointer and full-flag generator of the dual-clock FIFO.
// Owns the write pointer (binary + Gray), RAM write enable/address and the
// full, almost-full, overflow and fill-level flags. Flags are computed from
// the synchronized read pointer, so they may overstate the fill level while
// the read pointer is still crossing, but never understate it.
module wr_pntr_full
  import wr_pntr_full_pkg::*;
#(
  parameter int AWIDTH      = AWIDTH_DEF,
  parameter int ALMOST_FULL = ALMOST_FULL_DEF
) (
  input  logic           wr_clk_i,
  input  logic           aclr_i,
  wr_pntr_full_if.slave  bus
);
  localparam int PW = AWIDTH + 1;
  localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL);

  logic [PW-1:0] r_wbin;
  logic [PW-1:0] r_gray;
  logic          r_full;
  logic          r_afull;
  logic [PW-1:0] r_usedw;
  logic          r_ovf;

  logic          w_wr_en;
  logic [PW-1:0] w_wbin_nxt;
  logic [PW-1:0] w_gray_nxt;
  logic [PW-1:0] w_rbin;
  logic [PW-1:0] w_rd_gray_full;
  logic [PW-1:0] w_usedw_nxt;
  logic          w_full_nxt;
  logic          w_afull_nxt;

  wr_pntr_full_gray2bin #(
    .W (PW)
  ) u_rd_g2b (
    .i_gray (bus.rd_pntr_gray_i),
    .o_bin  (w_rbin)
  );

  // Next-state: accept decision, pointer advance and flag evaluation.
  always_comb begin
    w_wr_en        = bus.wr_req_i & ~r_full & aclr_i;
    w_wbin_nxt     = r_wbin + {{AWIDTH{1'b0}}, w_wr_en};
    w_gray_nxt     = w_wbin_nxt ^ (w_wbin_nxt >> 1);
    // Full when the write pointer is exactly one lap ahead: in Gray this is
    // the read pointer with its two MSBs inverted.
    w_rd_gray_full = {~bus.rd_pntr_gray_i[AWIDTH:AWIDTH-1],
                      bus.rd_pntr_gray_i[AWIDTH-2:0]};
    w_full_nxt     = (w_gray_nxt == w_rd_gray_full);
    w_usedw_nxt    = w_wbin_nxt - w_rbin;
    w_afull_nxt    = (w_usedw_nxt >= AF_LEVEL);
  end

  // Pointer and flag registers; asynchronous clear returns everything to empty.
  always_ff @(posedge wr_clk_i or negedge aclr_i) begin
    if (!aclr_i) begin
      r_wbin  <= {PW{1'b0}};
      r_gray  <= {PW{1'b0}};
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_usedw <= {PW{1'b0}};
      r_ovf   <= 1'b0;
    end else begin
      r_wbin  <= w_wbin_nxt;
      r_gray  <= w_gray_nxt;
      r_full  <= w_full_nxt;
      r_afull <= w_afull_nxt;
      r_usedw <= w_usedw_nxt;
      r_ovf   <= bus.wr_req_i & r_full;
    end
  end

  assign bus.wr_en_o          = w_wr_en;
  assign bus.wr_addr_o        = r_wbin[AWIDTH-1:0];
  assign bus.wr_pntr_gray_o   = r_gray;
  assign bus.wr_full_o        = r_full;
  assign bus.wr_almost_full_o = r_afull;
  assign bus.wr_usedw_o       = r_usedw;
  assign bus.wr_ovf_o         = r_ovf;

endmodule
